// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer_if
//  Purpose  : Bundles the sample input stream, result output stream,
//             coefficient write port and shared-multiplier operand/product
//             signals of the FIR MAC sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_sequencer_if #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          coef_we;
  logic [1:0]    coef_addr;
  logic [CW-1:0] coef_wdata;
  logic [DW-1:0] mult_a;
  logic [CW-1:0] mult_b;
  logic [AW-1:0] mult_p;

  // Environment side: offers samples, takes results, writes coefficients,
  // and owns the shared multiplier.
  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, mult_p,
    input  in_ready, out_valid, out_data, mult_a, mult_b
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, mult_p,
    output in_ready, out_valid, out_data, mult_a, mult_b
  );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer
//  Purpose  : 3-tap FIR y[n] = H0*x[n] + H1*x[n-1] + H2*x[n-2] computed with
//             one shared external multiplier over three MAC cycles per sample.
//             Coefficients are written to a shadow set and copied to the
//             active set only when a sample is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = 16
) (
  input  logic                clk,
  input  logic                rst,
  fir_mac_sequencer_if.slave  bus,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC0 = 3'd1,
    S_MAC1 = 3'd2,
    S_MAC2 = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] h0_s_q, h1_s_q, h2_s_q, h0_s_d, h1_s_d, h2_s_d;  // shadow
  logic [CW-1:0] h0_a_q, h1_a_q, h2_a_q, h0_a_d, h1_a_d, h2_a_d;  // active
  logic [DW-1:0] x0_q, x1_q, x2_q, x0_d, x1_d, x2_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] mult_a;
  logic [CW-1:0] mult_b;
  logic          in_ready;

  // Accept only when idle; forced low while reset is asserted.
  assign in_ready      = (state_q == S_IDLE) && !rst;
  assign busy          = (state_q != S_IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.mult_a    = mult_a;
  assign bus.mult_b    = mult_b;

  // Next-state, datapath updates and multiplier operand selection.
  always_comb begin
    state_d     = state_q;
    h0_s_d      = h0_s_q;
    h1_s_d      = h1_s_q;
    h2_s_d      = h2_s_q;
    h0_a_d      = h0_a_q;
    h1_a_d      = h1_a_q;
    h2_a_d      = h2_a_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mult_a      = '0;
    mult_b      = '0;

    // Shadow writes are accepted in every state; address 3 is unused.
    if (bus.coef_we) begin
      case (bus.coef_addr)
        2'd0:    h0_s_d = bus.coef_wdata;
        2'd1:    h1_s_d = bus.coef_wdata;
        2'd2:    h2_s_d = bus.coef_wdata;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready) begin
          x2_d    = x1_q;
          x1_d    = x0_q;
          x0_d    = bus.in_data;
          // Pre-edge shadow values: a same-cycle write waits for the next sample.
          h0_a_d  = h0_s_q;
          h1_a_d  = h1_s_q;
          h2_a_d  = h2_s_q;
          state_d = S_MAC0;
        end
      end
      S_MAC0: begin
        mult_a  = x0_q;
        mult_b  = h0_a_q;
        acc_d   = bus.mult_p;
        state_d = S_MAC1;
      end
      S_MAC1: begin
        mult_a  = x1_q;
        mult_b  = h1_a_q;
        acc_d   = acc_q + bus.mult_p;
        state_d = S_MAC2;
      end
      S_MAC2: begin
        mult_a      = x2_q;
        mult_b      = h2_a_q;
        out_data_d  = acc_q + bus.mult_p;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      h0_s_q      <= '0;
      h1_s_q      <= '0;
      h2_s_q      <= '0;
      h0_a_q      <= '0;
      h1_a_q      <= '0;
      h2_a_q      <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h0_s_q      <= h0_s_d;
      h1_s_q      <= h1_s_d;
      h2_s_q      <= h2_s_d;
      h0_a_q      <= h0_a_d;
      h1_a_q      <= h1_a_d;
      h2_a_q      <= h2_a_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_mac_sequencer
//  Purpose  : Directed self-checking bench for fir_mac_sequencer with a
//             behavioural model of the shared 8x8 multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  logic [7:0] ma [0:2];
  logic [7:0] mb [0:2];

  fir_mac_sequencer_if #(.DW(8), .CW(8), .AW(16)) bus ();

  fir_mac_sequencer #(.DW(8), .CW(8), .AW(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Shared combinational multiplier.
  assign bus.mult_p = 16'(bus.mult_a) * 16'(bus.mult_b);

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_vec("rst_in_ready", 32'(bus.in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check_vec("rst_busy", 32'(busy), 0);
    check_vec("rst_out_valid", 32'(bus.out_valid), 0);
    check_vec("rst_out_data", 32'(bus.out_data), 0);
    check_vec("rst_in_ready_after", 32'(bus.in_ready), 1);
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
    bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_wdata = d;
    tick();
    bus.coef_we = 1'b0;
  endtask

  task automatic set_h(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2);
    write_coef(2'd0, h0);
    write_coef(2'd1, h1);
    write_coef(2'd2, h2);
  endtask

  // Offers one sample from IDLE and checks the fixed-latency schedule.
  // wr_st: 0 = coefficient write in the accept cycle, 1..3 = during MAC0..MAC2,
  // anything else = no write. With rdy=0 the task returns while in OUT.
  task automatic do_sample(input logic [7:0] x, input logic [15:0] exp, input logic rdy,
                           input int wr_st, input logic [1:0] wa, input logic [7:0] wd);
    bus.out_ready = rdy;
    check_vec("idle_in_ready", 32'(bus.in_ready), 1);
    check_vec("idle_mult_a", 32'(bus.mult_a), 0);
    bus.in_valid = 1'b1; bus.in_data = x;
    if (wr_st == 0) begin
      bus.coef_we = 1'b1; bus.coef_addr = wa; bus.coef_wdata = wd;
    end
    tick();
    bus.in_valid = 1'b0; bus.coef_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_vec("mac_in_ready", 32'(bus.in_ready), 0);
      check_vec("mac_busy", 32'(busy), 1);
      check_vec("mac_out_valid", 32'(bus.out_valid), 0);
      ma[i] = bus.mult_a;
      mb[i] = bus.mult_b;
      if (wr_st == i + 1) begin
        bus.coef_we = 1'b1; bus.coef_addr = wa; bus.coef_wdata = wd;
      end
      tick();
      bus.coef_we = 1'b0;
    end
    check_vec("out_valid", 32'(bus.out_valid), 1);
    check_vec("out_data", 32'(bus.out_data), 32'(exp));
    check_vec("out_in_ready", 32'(bus.in_ready), 0);
    check_vec("out_mult_b", 32'(bus.mult_b), 0);
    if (rdy) begin
      tick();
      check_vec("post_out_valid", 32'(bus.out_valid), 0);
      check_vec("post_in_ready", 32'(bus.in_ready), 1);
      check_vec("post_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;

    // Basic stream: H=1,2,3, x=10,20,30 -> 10, 40, 100.
    do_reset();
    set_h(8'd1, 8'd2, 8'd3);
    do_sample(8'd10, 16'd10, 1'b1, -1, 2'd0, 8'd0);
    do_sample(8'd20, 16'd40, 1'b1, -1, 2'd0, 8'd0);
    do_sample(8'd30, 16'd100, 1'b1, -1, 2'd0, 8'd0);
    check_vec("seq_a0", 32'(ma[0]), 30);
    check_vec("seq_a1", 32'(ma[1]), 20);
    check_vec("seq_a2", 32'(ma[2]), 10);
    check_vec("seq_b0", 32'(mb[0]), 1);
    check_vec("seq_b1", 32'(mb[1]), 2);
    check_vec("seq_b2", 32'(mb[2]), 3);

    // Full-scale wraparound: 65025, 130050 mod 2^16, 195075 mod 2^16.
    do_reset();
    set_h(8'd255, 8'd255, 8'd255);
    do_sample(8'd255, 16'd65025, 1'b1, -1, 2'd0, 8'd0);
    do_sample(8'd255, 16'd64514, 1'b1, -1, 2'd0, 8'd0);
    do_sample(8'd255, 16'd64003, 1'b1, -1, 2'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      check_vec("max_mult_a", 32'(ma[i]), 255);
      check_vec("max_mult_b", 32'(mb[i]), 255);
    end

    // Backpressure: result held for 6 cycles, offered sample 99 ignored.
    do_reset();
    set_h(8'd1, 8'd2, 8'd3);
    do_sample(8'd10, 16'd10, 1'b0, -1, 2'd0, 8'd0);
    bus.in_valid = 1'b1; bus.in_data = 8'd99;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_vec("bp_out_valid", 32'(bus.out_valid), 1);
      check_vec("bp_out_data", 32'(bus.out_data), 10);
      check_vec("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_vec("bp_release_valid", 32'(bus.out_valid), 0);
    check_vec("bp_release_in_ready", 32'(bus.in_ready), 1);
    do_sample(8'd20, 16'd40, 1'b1, -1, 2'd0, 8'd0);

    // Coefficient timing: write during MAC1 only affects the next sample;
    // write in the accept cycle is deferred one sample.
    do_reset();
    set_h(8'd1, 8'd2, 8'd3);
    do_sample(8'd10, 16'd10, 1'b1, -1, 2'd0, 8'd0);
    do_sample(8'd20, 16'd40, 1'b1, 2, 2'd0, 8'd5);
    do_sample(8'd30, 16'd220, 1'b1, -1, 2'd0, 8'd0);
    do_sample(8'd40, 16'd320, 1'b1, 0, 2'd1, 8'd0);
    do_sample(8'd0, 16'd90, 1'b1, -1, 2'd0, 8'd0);

    // Reset during MAC1 aborts and clears coefficients/history.
    set_h(8'd1, 8'd2, 8'd3);
    bus.in_valid = 1'b1; bus.in_data = 8'd50;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_vec("abort_in_ready_rst", 32'(bus.in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check_vec("abort_busy", 32'(busy), 0);
    check_vec("abort_out_valid", 32'(bus.out_valid), 0);
    check_vec("abort_out_data", 32'(bus.out_data), 0);
    check_vec("abort_in_ready", 32'(bus.in_ready), 1);
    do_sample(8'd7, 16'd0, 1'b1, -1, 2'd0, 8'd0);

    // Address 3 write is a no-op.
    do_reset();
    set_h(8'd1, 8'd2, 8'd3);
    write_coef(2'd3, 8'd99);
    do_sample(8'd1, 16'd1, 1'b1, -1, 2'd0, 8'd0);
    do_sample(8'd1, 16'd3, 1'b1, -1, 2'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed controller for the 3-tap FIR. It computes y[n] = H0*x[n] + H1*x[n-1] + H2*x[n-2] using one shared external 8x8 braun_multiplier instead of three. The block accepts samples over a valid/ready handshake and keeps the two-sample history internally. It schedules three multiply-accumulate cycles per sample and presents each result over a valid/ready output handshake. Coefficients are written through a shadow register file and take effect cleanly on sample boundaries.

Parameters:
DW, 8, sample width (unsigned)
CW, 8, coefficient width (unsigned)
AW, 16, accumulator/output width; DW+CW, arithmetic modulo 2^AW

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  sample offered
in_ready  out  1  block can accept a sample
in_data  in  DW  sample x[n]
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  AW  y[n]
coef_we  in  1  shadow coefficient write strobe
coef_addr  in  2  0=H0, 1=H1, 2=H2, 3=ignored
coef_wdata  in  CW  coefficient value
mult_a  out  DW  operand to shared multiplier (sample)
mult_b  out  CW  operand to shared multiplier (coefficient)
mult_p  in  AW  combinational product mult_a*mult_b from shared multiplier
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clk edge) sets:
  - state=IDLE
  - shadow and active coefficients = 0
  - history x0, x1, x2 = 0
  - acc = 0
  - out_data = 0, out_valid = 0
- in_ready = (state==IDLE) && !rst. It is combinational, so it reads 0 while rst is high and 1 on the first cycle after reset.
- FSM states: IDLE, MAC0, MAC1, MAC2, OUT.
- IDLE:
  - On in_valid && in_ready: x2<=x1, x1<=x0, x0<=in_data.
  - Active coefficients <= shadow coefficients, using shadow values as registered before this edge.
  - Go to MAC0. Otherwise stay in IDLE.
- MAC0: mult_a=x0, mult_b=H0; acc<=mult_p; go to MAC1.
- MAC1: mult_a=x1, mult_b=H1; acc<=acc+mult_p; go to MAC2.
- MAC2: mult_a=x2, mult_b=H2; out_data<=acc+mult_p; out_valid<=1; go to OUT.
- OUT:
  - out_data and out_valid are held stable until out_ready.
  - On out_ready: out_valid<=0, go to IDLE.
  - A new sample can therefore be accepted no earlier than the cycle after the output handshake.
- mult_a and mult_b are driven to 0 in IDLE and OUT.
- Latency: a sample accepted at edge T gives out_valid=1 after edge T+3. With out_ready held high, maximum throughput is one sample per 5 cycles.
- Arithmetic: all values unsigned. Additions wrap modulo 2^AW; there is no saturation and no overflow flag.
- Coefficient writes:
  - coef_we writes shadow[coef_addr] at the clk edge, in any state. coef_addr=3 is a no-op.
  - Writes never disturb an in-flight computation. The active set changes only at sample acceptance.
  - A write in the same cycle as acceptance lands in the shadow register but is NOT used for that sample. It applies from the next sample.
- in_valid while busy is ignored; in_data is not sampled.
- Reset mid-operation (any state) aborts the computation and drops any pending output. History and coefficients return to 0.
- First two outputs after reset use zero history (x[-1]=x[-2]=0).

Test Plan:
- Reset, write H0=1, H1=2, H2=3, stream x=10,20,30 with out_ready=1 -> out_data=10, 40, 100. out_valid pulses 3 cycles after each accept; in_ready is low for 4 cycles after each accept.
- Write H0=H1=H2=255, stream x=255 three times -> third out_data=64003 (195075 mod 65536). Check mult_a/mult_b sequence 255/255 in MAC0..MAC2.
- Backpressure: out_ready=0 for 6 cycles after out_valid -> out_data and out_valid stable, in_ready=0 and in_valid ignored. Release -> handshake completes, in_ready=1 the next cycle.
- Coefficients H=1,2,3; write H0=5 during MAC1 of sample 20 (history 10) -> that output is 40. Next sample 30 -> 5*30+2*20+3*10=220. Write in the same cycle as accept -> not applied to that sample.
- Assert rst in MAC1 -> next cycle busy=0, out_valid=0, out_data=0, in_ready=1 after rst drops. Coefficients read back as 0 via sample x=7 -> out_data=0.
- coef_addr=3 write of 99 with H=1,2,3 and x=1 -> out_data=1 (no coefficient change).
